// File: rtl/one_to_eight_demux_seq.sv
// one_to_eight_demux_seq: collects 8 serial bits into a parallel word.
// A start pulse resynchronises framing to slot 0.
module one_to_eight_demux_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d,
    input  logic       d_valid,
    input  logic       start,
    output logic [7:0] y,
    output logic [2:0] s,
    output logic       y_valid,
    output logic       busy
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t     state, state_n;
    logic [2:0] s_n, slot, pos;
    logic [7:0] shadow, shadow_n, y_n;
    logic       y_valid_n;
    assign slot = start ? 3'd0 : s;
    assign pos  = MSB_FIRST ? 3'd7 - slot : slot;
    assign busy = (state == COLLECT);
    // start discards the partial frame first; a same-cycle capture then lands in slot 0
    always_comb begin
        state_n   = state;
        s_n       = s;
        shadow_n  = shadow;
        y_n       = y;
        y_valid_n = 1'b0;
        if (start) begin
            shadow_n = '0;
            s_n      = 3'd0;
            state_n  = IDLE;
        end
        if (d_valid) begin
            shadow_n[pos] = d;
            if (slot == 3'd7) begin
                y_n       = shadow_n;
                y_valid_n = 1'b1;
                s_n       = 3'd0;
                state_n   = IDLE;
                shadow_n  = '0;
            end else begin
                s_n     = slot + 3'd1;
                state_n = COLLECT;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= 3'd0;
            shadow  <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            shadow  <= shadow_n;
            y       <= y_n;
            y_valid <= y_valid_n;
        end
    end
endmodule

// File: tb/tb_one_to_eight_demux_seq.sv
// tb_one_to_eight_demux_seq: checks both slot orderings against a frame-level model.
module tb_one_to_eight_demux_seq;
    logic       clk = 1'b0;
    logic       rst_n, d, d_valid, start;
    logic [7:0] y0, y1;
    logic [2:0] s0, s1;
    logic       v0, v1, b0, b1;
    int         checks = 0;
    int         failures = 0;
    int         cnt = 0;
    bit         bits[8];
    logic [7:0] ey0 = '0, ey1 = '0;
    bit         ev = 1'b0;

    always #5 clk = ~clk;

    one_to_eight_demux_seq #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .start(start),
        .y(y0), .s(s0), .y_valid(v0), .busy(b0));
    one_to_eight_demux_seq #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .start(start),
        .y(y1), .s(s1), .y_valid(v1), .busy(b1));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Frame model: count of slots filled plus the bits received so far.
    task automatic model(input bit r, input bit dd, input bit dv, input bit st);
        ev = 1'b0;
        if (!r) begin
            cnt = 0; ey0 = '0; ey1 = '0;
        end else begin
            if (st) cnt = 0;
            if (dv) begin
                bits[cnt] = dd;
                cnt++;
                if (cnt == 8) begin
                    ey0 = '0; ey1 = '0;
                    for (int k = 0; k < 8; k++) begin
                        ey0 = ey0 + (8'(bits[k]) << k);
                        ey1 = ey1 + (8'(bits[k]) << (7 - k));
                    end
                    ev = 1'b1;
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit dd, input bit dv, input bit st);
        rst_n = r; d = dd; d_valid = dv; start = st;
        @(posedge clk);
        model(r, dd, dv, st);
        #1;
        chk("y_lsb", y0, ey0);
        chk("y_msb", y1, ey1);
        chk("s_lsb", {5'd0, s0}, 8'(cnt));
        chk("s_msb", {5'd0, s1}, 8'(cnt));
        chk("yv_lsb", {7'd0, v0}, {7'd0, ev});
        chk("yv_msb", {7'd0, v1}, {7'd0, ev});
        chk("busy_lsb", {7'd0, b0}, {7'd0, cnt != 0});
        chk("busy_msb", {7'd0, b1}, {7'd0, cnt != 0});
    endtask

    task automatic send(input logic [7:0] v, input int from, input int to);
        for (int k = from; k < to; k++) cyc(1, v[k], 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; d = 1'b0; d_valid = 1'b0; start = 1'b0;
        cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 0);
        // 1,0,1,1,0,0,1,0 in slot order
        send(8'b0100_1101, 0, 8);
        chk("frame_a_lsb", y0, 8'h4D);
        chk("frame_a_msb", y1, 8'hB2);
        chk("frame_a_pulse", {7'd0, v0}, 8'd1);
        send(8'hFF, 0, 7);
        chk("no_pulse_mid", {7'd0, v1}, 8'd0);
        send(8'hFF, 7, 8);
        chk("b2b_msb", y1, 8'hFF);
        chk("b2b_pulse", {7'd0, v1}, 8'd1);
        cyc(1, 0, 0, 0);
        chk("pulse_one_cycle", {7'd0, v0}, 8'd0);
        // gap mid-frame
        send(8'h4D, 0, 3);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0);
            chk("gap_hold_s", {5'd0, s0}, 8'd3);
        end
        send(8'h4D, 3, 8);
        chk("gap_word", y0, 8'h4D);
        // start discards partial frame
        send(8'h1F, 0, 5);
        cyc(1, 1, 1, 1);
        chk("start_s", {5'd0, s0}, 8'd1);
        send(8'h00, 1, 8);
        chk("restart_lsb", y0, 8'h01);
        chk("restart_msb", y1, 8'h80);
        // start without data returns to idle
        send(8'hFF, 0, 4);
        cyc(1, 1, 0, 1);
        chk("start_idle_busy", {7'd0, b0}, 8'd0);
        chk("start_idle_y", y0, 8'h01);
        // reset mid-frame
        send(8'hFF, 0, 4);
        cyc(0, 1, 1, 0);
        chk("rst_y", y0, 8'h00);
        send(8'hA5, 0, 8);
        chk("post_rst_lsb", y0, 8'hA5);
        chk("post_rst_msb", y1, 8'hA5);
        // every byte value
        for (int v = 0; v < 256; v++) begin
            send(8'(v), 0, 8);
            chk("exh_lsb", y0, 8'(v));
        end
        // random mix of gaps, starts and resets
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 49) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
